i2c_sync_filt: RTL and testbench

Parametrised successor to the two-line I2C input synchroniser. Each of SCL and SDA passes through a configurable-depth synchroniser and a per-line glitch filter. The block then produces registered "past" copies, single-cycle edge strobes, START/STOP condition strobes and a bus-busy flag. It sits between the I2C pads and the I2C slave/filter control logic, and is the only place raw bus lines enter the clock domain.

---
 rtl/myfilter_pkg.sv | 16 +
 rtl/i2c_glitch_filter.sv | 37 +++
 rtl/i2c_sync_filt.sv | 115 +++++++++++
 tb/tb_i2c_sync_filt.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
// Shared definitions for the I2C input synchroniser / glitch filter.
// Holds the default depths and the packed two-line bus vector type.
package myfilter_pkg;

    localparam int I2C_SYNC_STAGES_DEF = 2;
    localparam int I2C_FILT_CYCLES_DEF = 4;

    typedef struct packed {
        logic scl;
        logic sda;
    } i2c_lines_t;

    // Idle bus: both lines released (pulled high).
    localparam i2c_lines_t I2C_LINES_IDLE = '{scl: 1'b1, sda: 1'b1};

endpackage

// File: rtl/i2c_glitch_filter.sv
// Single-line glitch filter: a new synchronised level is accepted only after
// it has persisted for FILT_CYCLES consecutive cycles. Any return to the
// current level clears the counter, so no credit carries across glitches.
// Used by i2c_sync_filt only when I2C_SYNC_GLITCH_FILTER_EN is defined.
module i2c_glitch_filter #(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int CNT_W = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             filt_r;

    // Persistence counter and accepted level; idle level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            filt_r <= 1'b1;
        end else if (d == filt_r) begin
            cnt_r  <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            filt_r <= d;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    assign q = filt_r;

endmodule

// File: rtl/i2c_sync_filt.sv
// I2C pad-side front end: synchronises raw SCL/SDA into clk, optionally
// glitch-filters them, and derives past levels, edge strobes, START/STOP
// strobes and a bus-busy flag.
// Optional feature macro: I2C_SYNC_GLITCH_FILTER_EN (when undefined the
// filtered level is the synchroniser output and FILT_CYCLES has no effect).
module i2c_sync_filt
    import myfilter_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
    parameter int FILT_CYCLES = I2C_FILT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_out,
    output logic sda_out,
    output logic past_scl_out,
    output logic past_sda_out,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    // Reject out-of-range configurations at elaboration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_param
        $error("i2c_sync_filt: SYNC_STAGES or FILT_CYCLES out of range");
    end

    i2c_lines_t sync_r [SYNC_STAGES];
    i2c_lines_t sync_s;
    i2c_lines_t past_r;
    logic       scl_filt_s;
    logic       sda_filt_s;
    logic       bus_busy_r;

    // Multi-flop synchroniser chain for both lines, reset to idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= I2C_LINES_IDLE;
            end
        end else begin
            sync_r[0] <= '{scl: scl_in, sda: sda_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef I2C_SYNC_GLITCH_FILTER_EN
    i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_scl (
        .clk (clk),
        .rst (rst),
        .d   (sync_s.scl),
        .q   (scl_filt_s)
    );

    i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_sda (
        .clk (clk),
        .rst (rst),
        .d   (sync_s.sda),
        .q   (sda_filt_s)
    );
`else
    assign scl_filt_s = sync_s.scl;
    assign sda_filt_s = sync_s.sda;
`endif

    // One-cycle-delayed copies of the filtered levels for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            past_r <= I2C_LINES_IDLE;
        end else begin
            past_r.scl <= scl_filt_s;
            past_r.sda <= sda_filt_s;
        end
    end

    assign scl_out      = scl_filt_s;
    assign sda_out      = sda_filt_s;
    assign past_scl_out = past_r.scl;
    assign past_sda_out = past_r.sda;

    assign scl_rise = scl_filt_s & ~past_r.scl;
    assign scl_fall = ~scl_filt_s & past_r.scl;
    assign sda_rise = sda_filt_s & ~past_r.sda;
    assign sda_fall = ~sda_filt_s & past_r.sda;

    // SCL must be stable high across both cycles, otherwise it is data.
    assign start_det = sda_fall & scl_filt_s & past_r.scl;
    assign stop_det  = sda_rise & scl_filt_s & past_r.scl;

    // Bus-busy flag: set by START (including repeated START), cleared by STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_busy_r <= 1'b0;
        end else if (start_det) begin
            bus_busy_r <= 1'b1;
        end else if (stop_det) begin
            bus_busy_r <= 1'b0;
        end else begin
            bus_busy_r <= bus_busy_r;
        end
    end

    assign bus_busy = bus_busy_r;

endmodule

// File: tb/tb_i2c_sync_filt.sv
// Directed self-checking bench for i2c_sync_filt (SYNC_STAGES=2, FILT_CYCLES=4).
// Expected latencies depend on I2C_SYNC_GLITCH_FILTER_EN.
module tb_i2c_sync_filt;

`ifdef I2C_SYNC_GLITCH_FILTER_EN
    localparam int LAT      = 5;  // edge index at which f changes
    localparam int FILT_EFF = 4;  // shortest accepted pulse at s
`else
    localparam int LAT      = 1;
    localparam int FILT_EFF = 1;
`endif
    localparam int W = LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;
    logic scl_out, sda_out, past_scl_out, past_sda_out;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det, bus_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int n_sr = 0, n_sf = 0, n_dr = 0, n_df = 0, n_st = 0, n_sp = 0;
    int b_sr, b_sf, b_dr, b_df, b_st, b_sp;

    i2c_sync_filt #(.SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .scl_out      (scl_out),
        .sda_out      (sda_out),
        .past_scl_out (past_scl_out),
        .past_sda_out (past_sda_out),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .sda_rise     (sda_rise),
        .sda_fall     (sda_fall),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .bus_busy     (bus_busy)
    );

    always #5 clk = ~clk;

    // Strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (scl_rise)  n_sr <= n_sr + 1;
        if (scl_fall)  n_sf <= n_sf + 1;
        if (sda_rise)  n_dr <= n_dr + 1;
        if (sda_fall)  n_df <= n_df + 1;
        if (start_det) n_st <= n_st + 1;
        if (stop_det)  n_sp <= n_sp + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_sr = n_sr; b_sf = n_sf; b_dr = n_dr;
        b_df = n_df; b_st = n_st; b_sp = n_sp;
    endtask

    task automatic check_strobes(input string tag, input int sr, input int sf,
                                 input int dr, input int df, input int st, input int sp);
        check({tag, ".scl_rise_cnt"}, n_sr - b_sr, sr);
        check({tag, ".scl_fall_cnt"}, n_sf - b_sf, sf);
        check({tag, ".sda_rise_cnt"}, n_dr - b_dr, dr);
        check({tag, ".sda_fall_cnt"}, n_df - b_df, df);
        check({tag, ".start_cnt"},    n_st - b_st, st);
        check({tag, ".stop_cnt"},     n_sp - b_sp, sp);
    endtask

    // SDA low pulse of n cycles at the synchroniser output while SCL is high.
    task automatic glitch(input string tag, input int n);
        int acc;
        acc = (n >= FILT_EFF) ? 1 : 0;
        snap();
        sda_in = 1'b0;
        cyc(n);
        sda_in = 1'b1;
        cyc(LAT + n + 10);
        check({tag, ".sda_out"}, sda_out, 1'b1);
        check({tag, ".bus_busy"}, bus_busy, 1'b0);
        check_strobes(tag, 0, 0, acc, acc, acc, acc);
    endtask

    initial begin
        // Reset held
        repeat (3) @(posedge clk);
        #1;
        check("rst.scl_out", scl_out, 1'b1);
        check("rst.sda_out", sda_out, 1'b1);
        check("rst.past_scl", past_scl_out, 1'b1);
        check("rst.past_sda", past_sda_out, 1'b1);
        check("rst.bus_busy", bus_busy, 1'b0);
        rst = 1'b0;
        snap();
        cyc(20);
        check("idle.scl_out", scl_out, 1'b1);
        check("idle.sda_out", sda_out, 1'b1);
        check("idle.bus_busy", bus_busy, 1'b0);
        check_strobes("idle", 0, 0, 0, 0, 0, 0);

        // START: SDA falls while SCL high
        sda_in = 1'b0;
        cyc(LAT);
        check("start.pre_sda_out", sda_out, 1'b1);
        check("start.pre_start", start_det, 1'b0);
        cyc(1);
        check("start.sda_out", sda_out, 1'b0);
        check("start.sda_fall", sda_fall, 1'b1);
        check("start.start_det", start_det, 1'b1);
        check("start.busy_lag", bus_busy, 1'b0);
        cyc(1);
        check("start.start_gone", start_det, 1'b0);
        check("start.past_sda", past_sda_out, 1'b0);
        check("start.bus_busy", bus_busy, 1'b1);

        // Eight SCL pulses, data changed only while SCL low (byte 0xA5, LSB first)
        snap();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] data;
            data = 8'hA5;
            scl_in = 1'b0;
            cyc(W);
            sda_in = data[i];
            cyc(W);
            scl_in = 1'b1;
            cyc(W);
        end
        check("xfer.bus_busy", bus_busy, 1'b1);
        check("xfer.sda_out", sda_out, 1'b1);
        check_strobes("xfer", 8, 8, 4, 3, 0, 0);

        // Repeated START while busy
        sda_in = 1'b0;
        cyc(LAT + 1);
        check("rstart.start_det", start_det, 1'b1);
        cyc(1);
        check("rstart.bus_busy", bus_busy, 1'b1);

        // STOP: SDA rises while SCL high
        sda_in = 1'b1;
        cyc(LAT);
        check("stop.pre_stop", stop_det, 1'b0);
        cyc(1);
        check("stop.stop_det", stop_det, 1'b1);
        check("stop.sda_rise", sda_rise, 1'b1);
        check("stop.busy_lag", bus_busy, 1'b1);
        cyc(1);
        check("stop.stop_gone", stop_det, 1'b0);
        check("stop.bus_busy", bus_busy, 1'b0);
        cyc(W);

        // Glitches at s: 1, FILT-1 and FILT cycles
        glitch("glitch1", 1);
        glitch("glitch3", 3);
        glitch("glitch4", 4);

        // SCL and SDA fall together, then rise together: data, not conditions
        snap();
        scl_in = 1'b0;
        sda_in = 1'b0;
        cyc(LAT + 1);
        check("both.scl_fall", scl_fall, 1'b1);
        check("both.sda_fall", sda_fall, 1'b1);
        check("both.start_det", start_det, 1'b0);
        cyc(W);
        scl_in = 1'b1;
        sda_in = 1'b1;
        cyc(LAT + 1);
        check("both.scl_rise", scl_rise, 1'b1);
        check("both.sda_rise", sda_rise, 1'b1);
        check("both.stop_det", stop_det, 1'b0);
        cyc(W);
        check("both.bus_busy", bus_busy, 1'b0);
        check_strobes("both", 1, 1, 1, 1, 0, 0);

        // Reset mid-transfer while busy with SDA low
        sda_in = 1'b0;
        cyc(LAT + 3);
        check("mid.bus_busy_set", bus_busy, 1'b1);
        check("mid.sda_low", sda_out, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid.rst_busy", bus_busy, 1'b0);
        check("mid.rst_sda", sda_out, 1'b1);
        check("mid.rst_scl", scl_out, 1'b1);
        check("mid.rst_past_sda", past_sda_out, 1'b1);
        sda_in = 1'b1;
        snap();
        cyc(2);
        rst = 1'b0;
        cyc(20);
        check("post.sda_out", sda_out, 1'b1);
        check("post.bus_busy", bus_busy, 1'b0);
        check_strobes("post", 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
